uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmit path among NUM_REQ requesters.
- Targets the write_to_uart / tx_data / tx_full interface of the team UART module.
- Grants are message-granular: the owner keeps the transmitter until it flags its last byte, or until it stalls past a timeout.
- Prevents bytes from different requesters being interleaved on the serial line.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between NUM_REQ byte requesters, the arbiter and the UART write port.
// The arbiter takes the slave view: it consumes requests and tx_full and
// drives grant/ack and the UART write strobe/data.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ          = 4,
  parameter int TRANSMITTED_BITS = 8
);
  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ*TRANSMITTED_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]                  req_last;
  logic                                tx_full;
  logic [NUM_REQ-1:0]                  grant;
  logic [NUM_REQ-1:0]                  ack;
  logic                                write_to_uart;
  logic [TRANSMITTED_BITS-1:0]         tx_data;
  logic                                busy;

  // Requesters plus UART side (tx_full is the UART's FIFO status).
  modport master (
    output req, req_data, req_last, tx_full,
    input  grant, ack, write_to_uart, tx_data, busy
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, req_last, tx_full,
    output grant, ack, write_to_uart, tx_data, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one UART transmit port.
// Latency: grant 1 cycle after req is sampled; each byte is written 1 cycle after it is accepted.
// Backpressure: tx_full=1 stalls the owner without ageing its stall timer; max one byte per 2 clocks.
module uart_tx_arbiter #(
  parameter int          NUM_REQ          = 4,
  parameter int          TRANSMITTED_BITS = 8,
  parameter logic [15:0] STALL_TIMEOUT    = 16'd1000
) (
  input logic              clock_i,
  input logic              reset_i,
  uart_tx_arbiter_if.slave bus
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [IDXW-1:0]             owner_q, owner_d;
  logic [IDXW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [15:0]                 stall_q, stall_d;
  logic [NUM_REQ-1:0]          grant_q, grant_d;
  logic [NUM_REQ-1:0]          ack_q, ack_d;
  logic                        wr_q, wr_d;
  logic [TRANSMITTED_BITS-1:0] tx_data_q, tx_data_d;
  logic                        busy_q, busy_d;

  logic [TRANSMITTED_BITS-1:0] req_bytes [NUM_REQ];
  logic                        pick_vld;
  logic [IDXW-1:0]             pick_idx;
  logic [IDXW:0]               cand;
  logic [IDXW-1:0]             next_rr;

  // Split the flat data bus into one byte per requester.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = bus.req_data[i*TRANSMITTED_BITS +: TRANSMITTED_BITS];
    end
  end

  // Find the first active request at or after rr_ptr, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NUM_REQ)) begin
        cand = cand - (IDXW+1)'(NUM_REQ);
      end
      if (!pick_vld && bus.req[cand[IDXW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDXW-1:0];
      end
    end
  end

  // Pointer value after the current owner releases: the requester just after it.
  always_comb begin
    next_rr = (owner_q == IDXW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  end

  // Next-state and registered-output computation for the ownership FSM.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    stall_d   = stall_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    ack_d     = '0;
    wr_d      = 1'b0;
    tx_data_d = tx_data_q;

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          owner_d           = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          busy_d            = 1'b1;
          stall_d           = '0;
          state_d           = OWN;
        end
      end

      OWN: begin
        if (bus.req[owner_q]) begin
          // A full FIFO is the UART's problem, not the requester's: just wait.
          if (!bus.tx_full) begin
            wr_d           = 1'b1;
            tx_data_d      = req_bytes[owner_q];
            ack_d[owner_q] = 1'b1;
            stall_d        = '0;
            if (bus.req_last[owner_q]) begin
              grant_d  = '0;
              busy_d   = 1'b0;
              rr_ptr_d = next_rr;
              state_d  = IDLE;
            end else begin
              state_d = GAP;
            end
          end
        end else if (stall_q == STALL_TIMEOUT - 16'd1) begin
          // Owner went quiet for too long: take the transmitter back unwritten.
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = next_rr;
          stall_d  = '0;
          state_d  = IDLE;
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end

      // One dead cycle after each write so the requester can react to ack
      // and tx_full can reflect the byte just pushed.
      GAP: begin
        state_d = OWN;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      stall_q   <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      wr_q      <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      stall_q   <= stall_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      wr_q      <= wr_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.ack           = ack_q;
  assign bus.write_to_uart = wr_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: 4 requesters, 8-bit bytes, stall timeout 16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  uart_tx_arbiter_if #(.NUM_REQ(4), .TRANSMITTED_BITS(8)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(4),
    .TRANSMITTED_BITS(8),
    .STALL_TIMEOUT(16'd16)
  ) dut (
    .clock_i(clock),
    .reset_i(reset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic set_byte(input int i, input logic [7:0] d, input logic last);
    bus.req_data[i*8 +: 8] = d;
    bus.req_last[i]        = last;
  endtask

  // Advance up to budget falling edges, stopping on the first write strobe.
  task automatic wait_wr(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clock);
      if (bus.write_to_uart === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic apply_reset();
    reset        = 1'b1;
    bus.req      = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.tx_full  = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (bus.grant !== 4'b0000) begin miscompares++; $display("FAIL reset_grant: got %b want 0000", bus.grant); end
    vectors++; if (bus.ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b want 0000", bus.ack); end
    vectors++; if (bus.write_to_uart !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", bus.write_to_uart); end
    vectors++; if (bus.tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
    vectors++; if (dut.stall_q !== 16'd0) begin miscompares++; $display("FAIL reset_stall: got %0d want 0", dut.stall_q); end
  endtask

  task automatic test_single();
    logic [7:0] bytes [3];
    int         prev;
    bit         seen;
    bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
    set_byte(2, bytes[0], 1'b0);
    bus.req = 4'b0100;
    @(negedge clock);
    vectors++; if (bus.grant !== 4'b0100) begin miscompares++; $display("FAIL single_grant: got %b want 0100", bus.grant); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    prev = cyc;
    for (int b = 0; b < 3; b++) begin
      wait_wr(6, seen);
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL single_wr%0d: no write within 6 cycles", b); bus.req = '0; return; end
      vectors++; if (cyc - prev !== ((b == 0) ? 1 : 2)) begin miscompares++; $display("FAIL single_spacing%0d: got %0d cycles want %0d", b, cyc - prev, (b == 0) ? 1 : 2); end
      vectors++; if (bus.tx_data !== bytes[b]) begin miscompares++; $display("FAIL single_data%0d: got %h want %h", b, bus.tx_data, bytes[b]); end
      vectors++; if (bus.ack !== 4'b0100) begin miscompares++; $display("FAIL single_ack%0d: got %b want 0100", b, bus.ack); end
      prev = cyc;
      if (b < 2) set_byte(2, bytes[b+1], (b + 1) == 2);
      else begin bus.req = '0; bus.req_last = '0; end
    end
    vectors++; if (bus.grant !== 4'b0000) begin miscompares++; $display("FAIL single_release: got %b want 0000", bus.grant); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %b want 0", bus.busy); end
    vectors++; if (dut.rr_ptr_q !== 2'd3) begin miscompares++; $display("FAIL single_rr_ptr: got %0d want 3", dut.rr_ptr_q); end
  endtask

  task automatic test_contention();
    int         cnt [4];
    bit         seen;
    int         exp_own;
    logic [3:0] exp_ack;
    logic [7:0] exp_d;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      set_byte(i, 8'(i * 16), 1'b0);
    end
    bus.req = 4'b1111;
    for (int w = 0; w < 8; w++) begin
      wait_wr(10, seen);
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL cont_wr%0d: no write within 10 cycles", w); bus.req = '0; return; end
      exp_own = w / 2;
      exp_ack = 4'(1 << exp_own);
      exp_d   = 8'(exp_own * 16 + (w % 2));
      vectors++; if (bus.ack !== exp_ack) begin miscompares++; $display("FAIL cont_ack%0d: got %b want %b", w, bus.ack, exp_ack); end
      vectors++; if (bus.tx_data !== exp_d) begin miscompares++; $display("FAIL cont_data%0d: got %h want %h", w, bus.tx_data, exp_d); end
      for (int i = 0; i < 4; i++) begin
        if (bus.ack[i]) begin
          if (cnt[i] == 0) set_byte(i, 8'(i * 16 + 1), 1'b1);
          else begin bus.req[i] = 1'b0; bus.req_last[i] = 1'b0; end
          cnt[i]++;
        end
      end
    end
    vectors++; if (bus.grant !== 4'b0000) begin miscompares++; $display("FAIL cont_release: got %b want 0000", bus.grant); end
    vectors++; if (dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("FAIL cont_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
  endtask

  task automatic test_backpressure();
    bit seen;
    int bad;
    set_byte(1, 8'h55, 1'b0);
    bus.req = 4'b0010;
    wait_wr(8, seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL bp_first_wr: no write within 8 cycles"); bus.req = '0; return; end
    vectors++; if (bus.tx_data !== 8'h55) begin miscompares++; $display("FAIL bp_first_data: got %h want 55", bus.tx_data); end
    bus.tx_full = 1'b1;
    set_byte(1, 8'h66, 1'b1);
    bad = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (bus.write_to_uart !== 1'b0 || bus.ack !== 4'b0000 || bus.grant !== 4'b0010) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bp_hold: %0d bad cycles want 0", bad); end
    bus.tx_full = 1'b0;
    @(negedge clock);
    vectors++; if (bus.write_to_uart !== 1'b1) begin miscompares++; $display("FAIL bp_resume_wr: got %b want 1", bus.write_to_uart); end
    vectors++; if (bus.tx_data !== 8'h66) begin miscompares++; $display("FAIL bp_resume_data: got %h want 66", bus.tx_data); end
    vectors++; if (bus.ack !== 4'b0010) begin miscompares++; $display("FAIL bp_resume_ack: got %b want 0010", bus.ack); end
    vectors++; if (bus.grant !== 4'b0000) begin miscompares++; $display("FAIL bp_release: got %b want 0000", bus.grant); end
    bus.req = '0; bus.req_last = '0;
  endtask

  task automatic test_stall_timeout();
    bit seen;
    int bad;
    apply_reset();
    set_byte(0, 8'h77, 1'b0);
    set_byte(3, 8'h33, 1'b1);
    bus.req = 4'b1001;
    wait_wr(8, seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL stall_first_wr: no write within 8 cycles"); bus.req = '0; return; end
    vectors++; if (bus.ack !== 4'b0001) begin miscompares++; $display("FAIL stall_first_ack: got %b want 0001", bus.ack); end
    bus.req[0] = 1'b0;
    bad = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clock);
      if (bus.grant !== 4'b0001 || bus.write_to_uart !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL stall_hold: %0d bad cycles want 0", bad); end
    @(negedge clock);
    vectors++; if (bus.grant !== 4'b0000) begin miscompares++; $display("FAIL stall_release: got %b want 0000", bus.grant); end
    vectors++; if (bus.write_to_uart !== 1'b0) begin miscompares++; $display("FAIL stall_no_wr: got %b want 0", bus.write_to_uart); end
    @(negedge clock);
    vectors++; if (bus.grant !== 4'b1000) begin miscompares++; $display("FAIL stall_next_grant: got %b want 1000", bus.grant); end
    wait_wr(4, seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL stall_r3_wr: no write within 4 cycles"); bus.req = '0; return; end
    vectors++; if (bus.tx_data !== 8'h33) begin miscompares++; $display("FAIL stall_r3_data: got %h want 33", bus.tx_data); end
    bus.req = '0; bus.req_last = '0;
  endtask

  task automatic test_reset_mid_message();
    bit seen;
    set_byte(2, 8'hC1, 1'b0);
    bus.req = 4'b0100;
    wait_wr(8, seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rst_first_wr: no write within 8 cycles"); bus.req = '0; return; end
    vectors++; if (bus.ack !== 4'b0100) begin miscompares++; $display("FAIL rst_first_ack: got %b want 0100", bus.ack); end
    reset = 1'b1;
    @(negedge clock);
    reset   = 1'b0;
    bus.req = 4'b0010;
    set_byte(2, 8'h00, 1'b0);
    set_byte(1, 8'hB1, 1'b1);
    vectors++; if (bus.grant !== 4'b0000) begin miscompares++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.write_to_uart !== 1'b0) begin miscompares++; $display("FAIL rst_wr: got %b want 0", bus.write_to_uart); end
    vectors++; if (dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("FAIL rst_rr_ptr: got %0d want 0", dut.rr_ptr_q); end
    @(negedge clock);
    vectors++; if (bus.grant !== 4'b0010) begin miscompares++; $display("FAIL rst_regrant: got %b want 0010", bus.grant); end
    vectors++; if (bus.write_to_uart !== 1'b0) begin miscompares++; $display("FAIL rst_regrant_wr: got %b want 0", bus.write_to_uart); end
    wait_wr(4, seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL rst_r1_wr: no write within 4 cycles"); bus.req = '0; return; end
    vectors++; if (bus.tx_data !== 8'hB1) begin miscompares++; $display("FAIL rst_r1_data: got %h want B1", bus.tx_data); end
    bus.req = '0; bus.req_last = '0;
  endtask

  task automatic test_wrap_priority();
    bit seen;
    set_byte(2, 8'hD2, 1'b1);
    bus.req = 4'b0100;
    wait_wr(8, seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL wrap_r2_wr: no write within 8 cycles"); bus.req = '0; return; end
    vectors++; if (dut.rr_ptr_q !== 2'd3) begin miscompares++; $display("FAIL wrap_rr_ptr: got %0d want 3", dut.rr_ptr_q); end
    set_byte(2, 8'h00, 1'b0);
    set_byte(3, 8'hE3, 1'b1);
    set_byte(0, 8'hE0, 1'b1);
    bus.req = 4'b1001;
    @(negedge clock);
    vectors++; if (bus.grant !== 4'b1000) begin miscompares++; $display("FAIL wrap_first_grant: got %b want 1000", bus.grant); end
    wait_wr(4, seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL wrap_r3_wr: no write within 4 cycles"); bus.req = '0; return; end
    vectors++; if (bus.ack !== 4'b1000) begin miscompares++; $display("FAIL wrap_r3_ack: got %b want 1000", bus.ack); end
    vectors++; if (bus.tx_data !== 8'hE3) begin miscompares++; $display("FAIL wrap_r3_data: got %h want E3", bus.tx_data); end
    vectors++; if (dut.rr_ptr_q !== 2'd0) begin miscompares++; $display("FAIL wrap_rr_wrap: got %0d want 0", dut.rr_ptr_q); end
    bus.req[3] = 1'b0;
    wait_wr(6, seen);
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL wrap_r0_wr: no write within 6 cycles"); bus.req = '0; return; end
    vectors++; if (bus.ack !== 4'b0001) begin miscompares++; $display("FAIL wrap_r0_ack: got %b want 0001", bus.ack); end
    vectors++; if (bus.tx_data !== 8'hE0) begin miscompares++; $display("FAIL wrap_r0_data: got %h want E0", bus.tx_data); end
    bus.req = '0; bus.req_last = '0;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    bus.tx_full  = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_stall_timeout();
    test_reset_mid_message();
    test_wrap_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
